ika9958_vram_slot_arb: RTL and testbench
========================================

Name: ika9958_vram_slot_arb

Overview:
- Schedules VRAM access slots for the VDP core. Three requesters share the VRAM bus: display fetch, CPU port and command engine.
- Slot timing comes from the reset/clock control clock enables. One slot starts on each DLCLK-rate positive enable and lasts four phiA enables.
- Per slot the block selects one owner and emits the address strobe, data strobe and owner acknowledge at fixed phases.
- Sits between the RCC block and the VRAM interface/sequencer.

Parameters:
- AGE_MAX, 3: number of lost slots after which a pending CPU request beats the command engine regardless of round-robin state. Legal range 1..7.
- AGE_W, 3: width of the CPU age counter. Must satisfy 2^AGE_W > AGE_MAX.

Ports:
- i_phiA  in  1  internal master clock; all flops on posedge.
- i_RST  in  1  reset, synchronous, active-high.
- i_phiA_NCEN  in  1  21.48MHz enable. No state changes when low.
- i_phiL_PCEN  in  1  slot-start enable (DLCLK rate). Meaningful only when i_phiA_NCEN=1.
- i_DISP_REQ  in  1  display fetch request for the starting slot. Sampled at slot start only.
- i_CPU_REQ  in  1  CPU port request. Level; held until o_CPU_ACK.
- i_CMD_REQ  in  1  command engine request. Level; held until o_CMD_ACK.
- o_GNT  out  2  slot owner: 0 idle, 1 DISP, 2 CPU, 3 CMD.
- o_PHASE  out  2  phase within current slot, 0..3.
- o_ADDR_STB  out  1  address launch strobe.
- o_DATA_STB  out  1  data capture/drive strobe.
- o_DISP_ACK, o_CPU_ACK, o_CMD_ACK  out  1 each  access complete, one enabled cycle.
- o_CPU_AGED  out  1  CPU age counter is at AGE_MAX.

Behaviour:
- "Edge" below means a posedge i_phiA with i_phiA_NCEN=1. Nothing else updates state except i_RST.
- Reset (i_RST=1 at any posedge, enable ignored):
  - o_GNT=0, o_PHASE=3, all strobes and acks 0.
  - Age counter 0, rr bit 0 (CPU favoured), o_CPU_AGED=0.
  - An in-flight access is dropped and no ack is issued.
- Decision edge = edge with i_phiL_PCEN=1:
  - Effective request = raw request AND NOT (that requester's ack currently high). This prevents a double grant on the ack/decision overlap.
  - Priority 1: DISP if i_DISP_REQ.
  - Priority 2: CPU if pending and (aged OR CMD not pending OR rr=0).
  - Priority 3: CMD if pending.
  - Otherwise idle.
  - o_GNT <= winner. o_PHASE <= 0. o_ADDR_STB <= (winner != 0). Acks <= 0.
  - rr updates only when CPU or CMD wins: rr <= 1 after CPU, rr <= 0 after CMD.
  - Age counter: cleared if CPU wins or the effective CPU request is low; otherwise +1, saturating at AGE_MAX.
- Non-decision edges:
  - o_PHASE increments, saturating at 3.
  - Phase 0->1: o_ADDR_STB <= 0.
  - Phase 1->2: o_DATA_STB <= (o_GNT != 0).
  - Phase 2->3: o_DATA_STB <= 0; the ack matching o_GNT <= 1.
  - Already at 3: acks <= 0; o_GNT holds.
- Latency:
  - Grant visible 1 edge after the decision edge's sampling.
  - Ack high on the 4th edge of the slot, so a normal slot yields an ack exactly 3 edges after the grant.
- Early slot start (i_phiL_PCEN arrives before phase 3, e.g. DLCLK resync):
  - The new decision overrides immediately.
  - The truncated owner receives no ack and stays pending. Its age/rr are unchanged by the truncation.
- Long slot (no i_phiL_PCEN for more than 4 edges): phase holds at 3, GNT holds, no repeated ack.
- Simultaneous ack and decision on the same edge: the acked requester is excluded from arbitration on that edge.
- Requests dropped before ack: the grant and strobes still complete, and the ack still pulses. Requesters must tolerate this.
- At most one ack is high at any edge. o_ADDR_STB and o_DATA_STB are never high together.

Decomposition:
- Package ika9958_vram_pkg:
  - Owner enum (OWN_IDLE=0, OWN_DISP=1, OWN_CPU=2, OWN_CMD=3).
  - Phase constants PH_ADDR=0, PH_DATA=2, PH_ACK=3.
  - Default AGE_MAX.
- Optional sub-module ika9958_vram_slot_phase: phase counter plus strobe/ack generation, fed by o_GNT. The arbiter core (priority, rr, age) stays in the top.

Test Plan:
- Reset mid-slot: assert i_RST at phase 1 with GNT=2 -> next posedge GNT=0, PHASE=3, no o_CPU_ACK ever pulses for that slot.
- DISP priority: DISP, CPU, CMD all high at a decision edge -> GNT=1, ADDR_STB at phase 0, DATA_STB at phase 2, o_DISP_ACK at phase 3; CPU age becomes 1.
- Round-robin: CPU and CMD held high, no DISP, 4 slots -> GNT sequence 2,3,2,3; each ack asserted once per won slot.
- Aging with AGE_MAX=3: DISP high for 3 slots, CPU and CMD pending, rr=1 -> 4th slot GNT=2 despite rr; o_CPU_AGED high before that decision, 0 after.
- Early slot start: i_phiL_PCEN at phase 1 of a CMD slot -> no o_CMD_ACK; CMD re-granted in the new slot (no DISP/CPU) and acked at its phase 3.
- Ack/decision overlap: CPU_REQ kept high through its ack edge, with a decision on that edge and CMD low -> GNT=0 that slot; CPU granted again the following slot.

Source files
------------

// File: rtl/ika9958_vram_slot_arb_pkg.sv
// Shared owner encoding, slot phase constants and arbiter defaults for the
// VRAM slot arbiter.
package ika9958_vram_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_CMD  = 2'd3
  } owner_e;

  localparam logic [1:0] PH_ADDR = 2'd0;
  localparam logic [1:0] PH_WAIT = 2'd1;
  localparam logic [1:0] PH_DATA = 2'd2;
  localparam logic [1:0] PH_ACK  = 2'd3;

  localparam int unsigned AGE_MAX_DEFAULT = 3;

endpackage

// File: rtl/ika9958_vram_slot_arb_if.sv
// Request / grant / strobe bundle between the VRAM requesters and the slot
// arbiter.
interface ika9958_vram_slot_arb_if;

  logic       i_DISP_REQ;
  logic       i_CPU_REQ;
  logic       i_CMD_REQ;
  logic [1:0] o_GNT;
  logic [1:0] o_PHASE;
  logic       o_ADDR_STB;
  logic       o_DATA_STB;
  logic       o_DISP_ACK;
  logic       o_CPU_ACK;
  logic       o_CMD_ACK;
  logic       o_CPU_AGED;

  modport slave (
    input  i_DISP_REQ, i_CPU_REQ, i_CMD_REQ,
    output o_GNT, o_PHASE, o_ADDR_STB, o_DATA_STB,
    output o_DISP_ACK, o_CPU_ACK, o_CMD_ACK, o_CPU_AGED
  );

  modport master (
    output i_DISP_REQ, i_CPU_REQ, i_CMD_REQ,
    input  o_GNT, o_PHASE, o_ADDR_STB, o_DATA_STB,
    input  o_DISP_ACK, o_CPU_ACK, o_CMD_ACK, o_CPU_AGED
  );

endinterface

// File: rtl/ika9958_vram_slot_arb_phase.sv
// Slot phase counter with address/data strobes and the per-owner completion
// ack, driven by the arbiter's decision and current grant.
module ika9958_vram_slot_phase
  import ika9958_vram_pkg::*;
(
  input  logic       i_phiA,
  input  logic       i_RST,
  input  logic       i_ce,
  input  logic       i_dec,
  input  owner_e     i_win,
  input  owner_e     i_gnt,
  output logic [1:0] o_PHASE,
  output logic       o_ADDR_STB,
  output logic       o_DATA_STB,
  output logic       o_DISP_ACK,
  output logic       o_CPU_ACK,
  output logic       o_CMD_ACK
);

  always_ff @(posedge i_phiA) begin
    if (i_RST) begin
      o_PHASE    <= PH_ACK;
      o_ADDR_STB <= 1'b0;
      o_DATA_STB <= 1'b0;
      o_DISP_ACK <= 1'b0;
      o_CPU_ACK  <= 1'b0;
      o_CMD_ACK  <= 1'b0;
    end else if (i_ce) begin
      if (i_dec) begin
        // A decision restarts the slot from any phase; a truncated slot
        // therefore never reaches its ack.
        o_PHASE    <= PH_ADDR;
        o_ADDR_STB <= (i_win != OWN_IDLE);
        o_DATA_STB <= 1'b0;
        o_DISP_ACK <= 1'b0;
        o_CPU_ACK  <= 1'b0;
        o_CMD_ACK  <= 1'b0;
      end else begin
        if (o_PHASE != PH_ACK)
          o_PHASE <= o_PHASE + 2'd1;
        case (o_PHASE)
          PH_ADDR: o_ADDR_STB <= 1'b0;
          PH_WAIT: o_DATA_STB <= (i_gnt != OWN_IDLE);
          PH_DATA: begin
            o_DATA_STB <= 1'b0;
            o_DISP_ACK <= (i_gnt == OWN_DISP);
            o_CPU_ACK  <= (i_gnt == OWN_CPU);
            o_CMD_ACK  <= (i_gnt == OWN_CMD);
          end
          default: begin
            o_DISP_ACK <= 1'b0;
            o_CPU_ACK  <= 1'b0;
            o_CMD_ACK  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ika9958_vram_slot_arb.sv
// VRAM slot arbiter: picks one of display / CPU / command engine per DLCLK
// slot using fixed display priority, CPU/CMD round-robin and CPU aging.
module ika9958_vram_slot_arb
  import ika9958_vram_pkg::*;
#(
  parameter int unsigned AGE_MAX = AGE_MAX_DEFAULT,
  parameter int unsigned AGE_W   = 3
) (
  input  logic                     i_phiA,
  input  logic                     i_RST,
  input  logic                     i_phiA_NCEN,
  input  logic                     i_phiL_PCEN,
  ika9958_vram_slot_arb_if.slave   bus
);

  owner_e             gnt_q;
  owner_e             win;
  logic               rr_q;
  logic [AGE_W-1:0]   age_q;
  logic               dec;
  logic               cpu_eff;
  logic               cmd_eff;
  logic               aged;

  assign dec     = i_phiA_NCEN & i_phiL_PCEN;
  // A requester whose ack is still high must not win the overlapping decision.
  assign cpu_eff = bus.i_CPU_REQ & ~bus.o_CPU_ACK;
  assign cmd_eff = bus.i_CMD_REQ & ~bus.o_CMD_ACK;
  assign aged    = (age_q == AGE_W'(AGE_MAX));

  always_comb begin
    win = OWN_IDLE;
    if (bus.i_DISP_REQ)
      win = OWN_DISP;
    else if (cpu_eff && (aged || !cmd_eff || !rr_q))
      win = OWN_CPU;
    else if (cmd_eff)
      win = OWN_CMD;
  end

  always_ff @(posedge i_phiA) begin
    if (i_RST) begin
      gnt_q <= OWN_IDLE;
      rr_q  <= 1'b0;
      age_q <= '0;
    end else if (dec) begin
      gnt_q <= win;
      if (win == OWN_CPU)
        rr_q <= 1'b1;
      else if (win == OWN_CMD)
        rr_q <= 1'b0;
      if (win == OWN_CPU || !cpu_eff)
        age_q <= '0;
      else if (!aged)
        age_q <= age_q + 1'b1;
    end
  end

  assign bus.o_GNT      = gnt_q;
  assign bus.o_CPU_AGED = aged;

  ika9958_vram_slot_phase u_phase (
    .i_phiA     (i_phiA),
    .i_RST      (i_RST),
    .i_ce       (i_phiA_NCEN),
    .i_dec      (dec),
    .i_win      (win),
    .i_gnt      (gnt_q),
    .o_PHASE    (bus.o_PHASE),
    .o_ADDR_STB (bus.o_ADDR_STB),
    .o_DATA_STB (bus.o_DATA_STB),
    .o_DISP_ACK (bus.o_DISP_ACK),
    .o_CPU_ACK  (bus.o_CPU_ACK),
    .o_CMD_ACK  (bus.o_CMD_ACK)
  );

endmodule

// File: tb/tb_ika9958_vram_slot_arb.sv
// Directed bench for the VRAM slot arbiter: slot-level reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_ika9958_vram_slot_arb;

  localparam int AGE_MAX = 3;

  logic clk = 1'b0;
  logic rst, ce, pl;

  ika9958_vram_slot_arb_if bus();

  ika9958_vram_slot_arb #(.AGE_MAX(AGE_MAX), .AGE_W(3)) dut (
    .i_phiA      (clk),
    .i_RST       (rst),
    .i_phiA_NCEN (ce),
    .i_phiL_PCEN (pl),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Slot-level model: the owner of the current slot and how many enabled
  // edges have passed since it started (4 after reset: settled, no ack).
  int m_own = 0;
  int m_k   = 4;
  int m_age = 0;
  bit m_rr  = 1'b0;

  function automatic int pick(bit d, bit c, bit m, int age, bit rr);
    if (d) return 1;
    if (c && (age >= AGE_MAX || !m || !rr)) return 2;
    if (m) return 3;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    bit cpu_e, cmd_e;
    int w;
    if (rst) begin
      m_own = 0; m_k = 4; m_age = 0; m_rr = 1'b0;
    end else if (ce) begin
      if (pl) begin
        cpu_e = bus.i_CPU_REQ && !(m_k == 3 && m_own == 2);
        cmd_e = bus.i_CMD_REQ && !(m_k == 3 && m_own == 3);
        w = pick(bus.i_DISP_REQ, cpu_e, cmd_e, m_age, m_rr);
        if (w == 2) m_rr = 1'b1;
        if (w == 3) m_rr = 1'b0;
        if (w == 2 || !cpu_e) m_age = 0;
        else if (m_age < AGE_MAX) m_age = m_age + 1;
        m_own = w;
        m_k   = 0;
      end else if (m_k < 100) begin
        m_k = m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("gnt",      int'(bus.o_GNT),      m_own);
      check("phase",    int'(bus.o_PHASE),    (m_k >= 3) ? 3 : m_k);
      check("addr_stb", int'(bus.o_ADDR_STB), int'(m_k == 0 && m_own != 0));
      check("data_stb", int'(bus.o_DATA_STB), int'(m_k == 2 && m_own != 0));
      check("disp_ack", int'(bus.o_DISP_ACK), int'(m_k == 3 && m_own == 1));
      check("cpu_ack",  int'(bus.o_CPU_ACK),  int'(m_k == 3 && m_own == 2));
      check("cmd_ack",  int'(bus.o_CMD_ACK),  int'(m_k == 3 && m_own == 3));
      check("cpu_aged", int'(bus.o_CPU_AGED), int'(m_age == AGE_MAX));
      check("one_ack",
            int'(bus.o_DISP_ACK) + int'(bus.o_CPU_ACK) + int'(bus.o_CMD_ACK) > 1 ? 1 : 0, 0);
      check("stb_excl", int'(bus.o_ADDR_STB & bus.o_DATA_STB), 0);
    end
  end

  task automatic tick(input bit p);
    ce = 1'b1; pl = p;
    @(posedge clk); #1;
    ce = 1'b0; pl = 1'b0;
  endtask

  task automatic stall(input int n);
    ce = 1'b0; pl = 1'b1;
    repeat (n) @(posedge clk);
    #1; pl = 1'b0;
  endtask

  task automatic rest3();
    repeat (3) tick(1'b0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ce = 1'b0; pl = 1'b0;
    bus.i_DISP_REQ = 1'b0; bus.i_CPU_REQ = 1'b0; bus.i_CMD_REQ = 1'b0;
    @(posedge clk); #1;
    started = 1'b1;
    tick(1'b1);
    check("rst_gnt", int'(bus.o_GNT), 0);
    check("rst_phase", int'(bus.o_PHASE), 3);
    check("rst_aged", int'(bus.o_CPU_AGED), 0);
    rst = 1'b0;

    // Display wins over everything
    bus.i_DISP_REQ = 1'b1; bus.i_CPU_REQ = 1'b1; bus.i_CMD_REQ = 1'b1;
    tick(1'b1);
    check("disp_gnt", int'(bus.o_GNT), 1);
    check("disp_addr", int'(bus.o_ADDR_STB), 1);
    bus.i_DISP_REQ = 1'b0;
    tick(1'b0);
    check("disp_ph1_addr", int'(bus.o_ADDR_STB), 0);
    tick(1'b0);
    check("disp_data", int'(bus.o_DATA_STB), 1);
    tick(1'b0);
    check("disp_ack", int'(bus.o_DISP_ACK), 1);
    check("disp_ph3_data", int'(bus.o_DATA_STB), 0);

    // Round-robin CPU/CMD, with a disabled stretch carrying a stray PCEN
    tick(1'b1);
    check("rr1_gnt", int'(bus.o_GNT), 2);
    stall(3);
    check("stall_phase", int'(bus.o_PHASE), 0);
    check("stall_addr", int'(bus.o_ADDR_STB), 1);
    rest3();
    check("rr1_ack", int'(bus.o_CPU_ACK), 1);
    tick(1'b1);
    check("rr2_gnt", int'(bus.o_GNT), 3);
    rest3();
    check("rr2_ack", int'(bus.o_CMD_ACK), 1);
    tick(1'b1);
    check("rr3_gnt", int'(bus.o_GNT), 2);
    rest3();
    tick(1'b1);
    check("rr4_gnt", int'(bus.o_GNT), 3);
    rest3();

    // CPU slot sets rr=1, then a long slot lets the ack drop
    tick(1'b1);
    check("pre_age_gnt", int'(bus.o_GNT), 2);
    rest3();
    tick(1'b0);
    check("long_phase", int'(bus.o_PHASE), 3);
    check("long_ack", int'(bus.o_CPU_ACK), 0);
    check("long_gnt", int'(bus.o_GNT), 2);

    // Three display slots age the pending CPU request
    bus.i_DISP_REQ = 1'b1;
    repeat (3) begin
      tick(1'b1);
      check("age_disp_gnt", int'(bus.o_GNT), 1);
      rest3();
    end
    check("aged_before", int'(bus.o_CPU_AGED), 1);
    bus.i_DISP_REQ = 1'b0;
    tick(1'b1);
    check("aged_gnt", int'(bus.o_GNT), 2);
    check("aged_after", int'(bus.o_CPU_AGED), 0);
    rest3();

    // Early slot start truncates a CMD slot; CMD is granted again
    bus.i_CPU_REQ = 1'b0;
    tick(1'b1);
    check("early_gnt0", int'(bus.o_GNT), 3);
    tick(1'b0);
    tick(1'b1);
    check("early_gnt1", int'(bus.o_GNT), 3);
    check("early_phase", int'(bus.o_PHASE), 0);
    check("early_noack", int'(bus.o_CMD_ACK), 0);
    rest3();
    check("early_ack", int'(bus.o_CMD_ACK), 1);
    bus.i_CMD_REQ = 1'b0;

    // CPU held through its ack: excluded at the overlapping decision
    bus.i_CPU_REQ = 1'b1;
    tick(1'b1);
    check("ovl_gnt0", int'(bus.o_GNT), 2);
    rest3();
    tick(1'b1);
    check("ovl_idle", int'(bus.o_GNT), 0);
    check("ovl_addr", int'(bus.o_ADDR_STB), 0);
    rest3();
    check("idle_noack", int'(bus.o_CPU_ACK), 0);
    tick(1'b1);
    check("ovl_regnt", int'(bus.o_GNT), 2);

    // Reset mid-slot (phase 1, CPU), enable low
    tick(1'b0);
    check("mid_phase", int'(bus.o_PHASE), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_gnt", int'(bus.o_GNT), 0);
    check("mid_rst_phase", int'(bus.o_PHASE), 3);
    rst = 1'b0; bus.i_CPU_REQ = 1'b0;
    repeat (3) begin
      tick(1'b0);
      check("mid_rst_noack", int'(bus.o_CPU_ACK), 0);
    end

    // Request dropped after grant still completes with an ack
    bus.i_CMD_REQ = 1'b1;
    tick(1'b1);
    check("drop_gnt", int'(bus.o_GNT), 3);
    bus.i_CMD_REQ = 1'b0;
    rest3();
    check("drop_ack", int'(bus.o_CMD_ACK), 1);
    tick(1'b0);
    tick(1'b0);
    check("drop_noreack", int'(bus.o_CMD_ACK), 0);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
